// File: rtl/sample_delay_line.sv
// sample_delay_line: ring-buffer delay line. Each enabled sample is written
// into a dual-port RAM at wr_ptr and the sample written 'delay' samples earlier
// is read back, appearing on dout one cycle later. A small state machine tracks
// whether enough history exists for the current delay.
module sample_delay_line #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [A_WIDTH-1:0] delay,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               primed
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0] FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_addr;
  logic [A_WIDTH:0]   fill;
  logic [A_WIDTH:0]   fill_nxt;
  logic [A_WIDTH:0]   delay_ext;
  state_t             state;
  state_t             state_nxt;

  assign delay_ext = {1'b0, delay};
  assign rd_addr   = wr_ptr - delay;
  assign fill_nxt  = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign primed    = (state == RUN);

  // Sample storage; contents survive reset, and a sample presented during reset is dropped
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Datapath: pointer, fill count and the registered delayed sample
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (en) begin
      wr_ptr     <= wr_ptr + 1'b1;
      fill       <= fill_nxt;
      dout       <= (delay == '0) ? din : mem[rd_addr];
      dout_valid <= (fill >= delay_ext);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: RUN whenever the following sample will be backed by real history
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    state_nxt = (delay == '0) ? RUN : PRIME;
        PRIME:   if (fill_nxt >= delay_ext) state_nxt = RUN;
        RUN:     if (fill_nxt < delay_ext) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_delay_line.sv
// tb_sample_delay_line: directed checks of the delay line, using a full-size
// instance plus a 16-deep instance for the wrap-around scenario.
module tb_sample_delay_line;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] delay;
  logic [7:0] dout;
  logic       dout_valid;
  logic       primed;

  logic       s_rst;
  logic       s_en;
  logic [7:0] s_din;
  logic [3:0] s_delay;
  logic [7:0] s_dout;
  logic       s_dout_valid;
  logic       s_primed;

  int checks   = 0;
  int failures = 0;

  sample_delay_line #(.A_WIDTH(8), .D_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .delay      (delay),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  sample_delay_line #(.A_WIDTH(4), .D_WIDTH(8)) dut_small (
    .clk        (clk),
    .rst        (s_rst),
    .en         (s_en),
    .din        (s_din),
    .delay      (s_delay),
    .dout       (s_dout),
    .dout_valid (s_dout_valid),
    .primed     (s_primed)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic e, input logic [7:0] d);
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic s_step(input logic r, input logic e, input logic [7:0] d);
    s_rst = r;
    s_en  = e;
    s_din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    delay = 8'd0;
    step(1'b1, 1'b0, 8'h00);
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_dout: got %h expected 00", dout);
    end
    checks++;
    if (dout_valid !== 1'b0 || primed !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got valid=%b primed=%b expected 0 0", dout_valid, primed);
    end
  endtask

  task automatic test_zero_delay;
    step(1'b1, 1'b0, 8'h00);
    delay = 8'd0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 8'(i));
      checks++;
      if (dout !== 8'(i) || dout_valid !== 1'b1 || primed !== 1'b1) begin
        failures++;
        $display("[TB] FAIL zero_delay[%0d]: got dout=%h valid=%b primed=%b expected %h 1 1",
                 i, dout, dout_valid, primed, 8'(i));
      end
    end
  endtask

  task automatic test_delay3;
    logic exp_valid [5];
    logic exp_primed [5];
    exp_valid  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_primed = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    step(1'b1, 1'b0, 8'h00);
    delay = 8'd3;
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 8'(10 + n));
      checks++;
      if (dout_valid !== exp_valid[n] || primed !== exp_primed[n]) begin
        failures++;
        $display("[TB] FAIL delay3_flags[%0d]: got valid=%b primed=%b expected %b %b",
                 n, dout_valid, primed, exp_valid[n], exp_primed[n]);
      end
      if (n >= 3) begin
        checks++;
        if (dout !== 8'(10 + n - 3)) begin
          failures++;
          $display("[TB] FAIL delay3_dout[%0d]: got %h expected %h", n, dout, 8'(10 + n - 3));
        end
      end
    end
  endtask

  task automatic test_wrap;
    s_delay = 4'd15;
    s_step(1'b1, 1'b0, 8'h00);
    for (int n = 0; n <= 40; n++) begin
      s_step(1'b0, 1'b1, 8'(n));
      checks++;
      if (s_dout_valid !== (n >= 15)) begin
        failures++;
        $display("[TB] FAIL wrap_valid[%0d]: got %b expected %b", n, s_dout_valid, (n >= 15));
      end
      if (n >= 15) begin
        checks++;
        if (s_dout !== 8'(n - 15)) begin
          failures++;
          $display("[TB] FAIL wrap_dout[%0d]: got %h expected %h", n, s_dout, 8'(n - 15));
        end
      end
    end
  endtask

  task automatic test_enable_hold;
    step(1'b1, 1'b0, 8'h00);
    delay = 8'd1;
    step(1'b0, 1'b1, 8'd20);
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_first_valid: got %b expected 0", dout_valid);
    end
    step(1'b0, 1'b1, 8'd21);
    checks++;
    if (dout !== 8'd20 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_second: got dout=%0d valid=%b expected 20 1", dout, dout_valid);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'd99);
      checks++;
      if (dout !== 8'd20 || dout_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hold_idle[%0d]: got dout=%0d valid=%b expected 20 1", i, dout, dout_valid);
      end
    end
    step(1'b0, 1'b1, 8'd22);
    checks++;
    if (dout !== 8'd21 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_resume: got dout=%0d valid=%b expected 21 1", dout, dout_valid);
    end
  endtask

  task automatic test_delay_raise;
    step(1'b1, 1'b0, 8'h00);
    delay = 8'd2;
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 8'(100 + n));
    checks++;
    if (primed !== 1'b1 || dout !== 8'd102 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL raise_before: got primed=%b dout=%0d valid=%b expected 1 102 1",
               primed, dout, dout_valid);
    end
    delay = 8'd8;
    for (int n = 5; n <= 8; n++) begin
      step(1'b0, 1'b1, 8'(100 + n));
      checks++;
      if (dout_valid !== (n >= 8)) begin
        failures++;
        $display("[TB] FAIL raise_valid[%0d]: got %b expected %b", n, dout_valid, (n >= 8));
      end
      if (n == 5) begin
        checks++;
        if (primed !== 1'b0) begin
          failures++;
          $display("[TB] FAIL raise_prime: got primed=%b expected 0", primed);
        end
      end
    end
    checks++;
    if (primed !== 1'b1 || dout !== 8'd100) begin
      failures++;
      $display("[TB] FAIL raise_after: got primed=%b dout=%0d expected 1 100", primed, dout);
    end
  endtask

  task automatic test_reset_midstream;
    step(1'b1, 1'b0, 8'h00);
    delay = 8'd0;
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h44);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    checks++;
    if (dout !== 8'h55 || primed !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre: got dout=%h primed=%b expected 55 1", dout, primed);
    end
    step(1'b1, 1'b1, 8'hAA);
    checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || primed !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs: got dout=%h valid=%b primed=%b expected 00 0 0",
               dout, dout_valid, primed);
    end
    delay = 8'd255;
    step(1'b0, 1'b1, 8'h66);
    checks++;
    if (dout !== 8'h22 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_discard: got dout=%h valid=%b expected 22 0", dout, dout_valid);
    end
  endtask

  // Run every scenario in sequence, then report
  initial begin
    rst = 1'b1; en = 1'b0; din = '0; delay = '0;
    s_rst = 1'b1; s_en = 1'b0; s_din = '0; s_delay = '0;
    test_reset();
    test_zero_delay();
    test_delay3();
    test_wrap();
    test_enable_hold();
    test_delay_raise();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
